vote_result_reader: RTL and testbench
=====================================

VOTE_RESULT_READER -- requirements
Module: vote_result_reader

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of each candidate count.
REQ-002 Port clock, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: SHALL be the asynchronous, active-low reset.
REQ-004 Port mode, input, 1: SHALL mean 1 = result mode (readout permitted) and 0 = voting mode.
REQ-005 Port start, input, 1: SHALL be a single-cycle request to begin one readout.
REQ-006 Ports cand1_count..cand4_count, input, CNT_W each: SHALL carry the live vote totals from the vote counter.
REQ-007 Port rd_valid, output, 1: SHALL flag that a readout record is presented.
REQ-008 Port rd_ready, input, 1: SHALL be the consumer's acceptance of a record.
REQ-009 Port rd_kind, output, 1: SHALL mean 0 = per-candidate count record and 1 = winner record.
REQ-010 Port rd_id, output, 2: SHALL carry the candidate index 0..3.
REQ-011 Port rd_data, output, CNT_W: SHALL carry the count for rd_id.
REQ-012 Port busy, output, 1: SHALL be high while a readout is in progress.
REQ-013 Port winner_id, output, 2, and port winner_valid, output, 1: SHALL carry the latched winner and its valid flag.
REQ-014 Port tie, output, 1: SHALL flag that two or more candidates share the maximum (present only with VOTE_READER_TIE_DETECT_EN).

Function
REQ-015 FSM states SHALL be IDLE, SEND and WIN.
REQ-016 In IDLE, start=1 with mode=1 SHALL snapshot all four counts and enter SEND with index 0 on the next edge; start with mode=0 SHALL be ignored.
REQ-017 In SEND, rd_valid=1, rd_kind=0, rd_id=index and rd_data=snapshot[index] SHALL be presented.
REQ-018 A handshake SHALL be the condition rd_valid & rd_ready on a rising edge; each handshake in SEND SHALL advance the index, and the handshake at index 3 SHALL enter WIN.
REQ-019 Presented record fields SHALL hold stable while rd_valid=1 and rd_ready=0; there SHALL be no combinational path from rd_ready to rd_valid.
REQ-020 Max tracking SHALL update on each SEND handshake; a count replaces the running max only if strictly greater, so ties resolve to the lowest index.
REQ-021 In WIN, rd_valid=1, rd_kind=1, rd_id=winner and rd_data=max count SHALL be presented; the handshake SHALL return to IDLE, load winner_id and set winner_valid=1.
REQ-022 winner_valid SHALL stay high until the next accepted start or until mode=0, which SHALL clear it.
REQ-023 A back-to-back readout SHALL be allowed: start is accepted in the cycle after WIN completes.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 mode falling to 0 in SEND or WIN SHALL abort: the next edge enters IDLE, with rd_valid=0 and winner_valid=0, and a partial result SHALL NOT be latched.
REQ-026 Changes on candN_count during a readout SHALL NOT affect any output; only the snapshot is used.
REQ-027 When all counts are zero, the winner SHALL be id 0 with count 0.
REQ-028 Count arithmetic SHALL be comparison only, unsigned, CNT_W wide, with no wrap.
REQ-029 busy SHALL be 1 in SEND and WIN and 0 in IDLE.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, index 0, rd_valid=0, rd_kind=0, rd_id=0, rd_data=0, busy=0, winner_id=0, winner_valid=0, tie=0, and clear the snapshot and max.
REQ-031 Reset asserted mid-readout SHALL discard the readout; no record SHALL be emitted after release until a new start.

Configuration
REQ-032 With macro VOTE_READER_TIE_DETECT_EN defined, tie SHALL latch with winner_id: it is 1 if any other snapshot count equals the max, and it SHALL clear on the same conditions as winner_valid.
REQ-033 Without VOTE_READER_TIE_DETECT_EN, the tie port SHALL be absent and lowest-index tie resolution (REQ-020) SHALL be the only behaviour.

Structure
REQ-034 Shared package vote_pkg SHALL hold the candidate count constant (4), the candidate-id width (2), the FSM state enum, and the rd_kind encodings (KIND_COUNT=0, KIND_WIN=1).
REQ-035 One sub-module, vote_max_tracker, SHALL hold the running max, its id and the tie flag, with clear and update inputs.

Verification
REQ-036 mode=1, counts 5/9/3/7, start, rd_ready=1 -> four records (0,5), (1,9), (2,3), (3,7), then winner (1,9); winner_valid=1, tie=0.
REQ-037 counts 4/8/8/2 -> winner id 1 with count 8; tie=1 when TIE_DETECT_EN is defined.
REQ-038 rd_ready held 0 for 3 cycles on record 2 -> rd_id=2 and rd_data stable for all 3 cycles; no record skipped.
REQ-039 mode=0 with start -> no rd_valid and busy stays 0; mode dropped to 0 during record 1 -> IDLE next cycle, winner_valid=0.
REQ-040 cand3_count changed from 3 to 200 after start -> record 2 still reports 3; winner unchanged.
REQ-041 reset asserted mid-SEND -> all outputs 0 asynchronously; all counts 0 then start -> winner (0,0).

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the vote result reader: candidate geometry,
// readout FSM states and record-kind encodings.
package vote_pkg;

  localparam int unsigned NUM_CAND  = 4;
  localparam int unsigned CAND_ID_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  localparam logic KIND_COUNT = 1'b0;
  localparam logic KIND_WIN   = 1'b1;

endpackage

// File: rtl/vote_max_tracker.sv
// Running-maximum tracker for the readout sequence.
// Holds the largest count seen so far, the lowest index that produced it,
// and (with VOTE_READER_TIE_DETECT_EN) whether a later index matched it.
module vote_max_tracker
  import vote_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 update,
  input  logic                 upd_first,
  input  logic [CAND_ID_W-1:0] upd_id,
  input  logic [CNT_W-1:0]     upd_count,
  output logic [CNT_W-1:0]     max_count,
  output logic [CAND_ID_W-1:0] max_id
`ifdef VOTE_READER_TIE_DETECT_EN
  ,
  output logic                 tie
`endif
);

  logic take_new;

  // First update always loads; later ones only when strictly greater,
  // so equal counts keep the lowest index.
  always_comb begin
    take_new = upd_first || (upd_count > max_count);
  end

  // Running max and its index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_count <= '0;
      max_id    <= '0;
    end else if (clear) begin
      max_count <= '0;
      max_id    <= '0;
    end else if (update && take_new) begin
      max_count <= upd_count;
      max_id    <= upd_id;
    end
  end

`ifdef VOTE_READER_TIE_DETECT_EN
  // A new strict max drops any earlier tie; an equal later count raises it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tie <= 1'b0;
    end else if (clear) begin
      tie <= 1'b0;
    end else if (update) begin
      if (take_new) begin
        tie <= 1'b0;
      end else if (upd_count == max_count) begin
        tie <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/vote_result_reader.sv
// Vote result reader: on request in result mode, snapshots the four
// candidate totals and streams them out as valid/ready records followed by
// a winner record, then latches the winner.
// Optional feature macro: VOTE_READER_TIE_DETECT_EN adds the tie output.
module vote_result_reader
  import vote_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cand1_count,
  input  logic [CNT_W-1:0]     cand2_count,
  input  logic [CNT_W-1:0]     cand3_count,
  input  logic [CNT_W-1:0]     cand4_count,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 rd_kind,
  output logic [CAND_ID_W-1:0] rd_id,
  output logic [CNT_W-1:0]     rd_data,
  output logic                 busy,
  output logic [CAND_ID_W-1:0] winner_id,
  output logic                 winner_valid
`ifdef VOTE_READER_TIE_DETECT_EN
  ,
  output logic                 tie
`endif
);

  state_t               state_q, state_d;
  logic [CAND_ID_W-1:0] idx_q;
  logic [CNT_W-1:0]     snap_q [NUM_CAND];

  logic start_acc;
  logic send_hs;
  logic win_hs;
  logic abort;

  logic [CNT_W-1:0]     trk_max;
  logic [CAND_ID_W-1:0] trk_id;
`ifdef VOTE_READER_TIE_DETECT_EN
  logic                 trk_tie;
  logic                 tie_q;
`endif

  // Next-state and handshake decode; abort on mode=0 wins over a handshake
  // in the same cycle so a partial result is never latched.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    send_hs   = 1'b0;
    win_hs    = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && mode) begin
          start_acc = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!mode) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          send_hs = 1'b1;
          if (idx_q == CAND_ID_W'(NUM_CAND - 1)) begin
            state_d = ST_WIN;
          end
        end
      end
      ST_WIN: begin
        if (!mode) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          win_hs  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Record presentation depends only on registered state, never on rd_ready.
  always_comb begin
    rd_valid = 1'b0;
    rd_kind  = KIND_COUNT;
    rd_id    = '0;
    rd_data  = '0;
    busy     = 1'b0;
    unique case (state_q)
      ST_SEND: begin
        rd_valid = 1'b1;
        rd_kind  = KIND_COUNT;
        rd_id    = idx_q;
        rd_data  = snap_q[idx_q];
        busy     = 1'b1;
      end
      ST_WIN: begin
        rd_valid = 1'b1;
        rd_kind  = KIND_WIN;
        rd_id    = trk_id;
        rd_data  = trk_max;
        busy     = 1'b1;
      end
      default: begin
        rd_valid = 1'b0;
      end
    endcase
  end

  // State, index, snapshot and latched winner registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      winner_id    <= '0;
      winner_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        idx_q        <= '0;
        winner_valid <= 1'b0;
        snap_q[0]    <= cand1_count;
        snap_q[1]    <= cand2_count;
        snap_q[2]    <= cand3_count;
        snap_q[3]    <= cand4_count;
      end else if (send_hs) begin
        idx_q <= idx_q + CAND_ID_W'(1);
      end else if (abort) begin
        idx_q <= '0;
      end
      if (win_hs) begin
        winner_id    <= trk_id;
        winner_valid <= 1'b1;
      end else if (!mode) begin
        winner_valid <= 1'b0;
      end
    end
  end

`ifdef VOTE_READER_TIE_DETECT_EN
  // Tie flag latches with the winner and clears alongside winner_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tie_q <= 1'b0;
    end else if (start_acc || (!win_hs && !mode)) begin
      tie_q <= 1'b0;
    end else if (win_hs) begin
      tie_q <= trk_tie;
    end
  end

  assign tie = tie_q;
`endif

  vote_max_tracker #(
    .CNT_W (CNT_W)
  ) u_max (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_acc),
    .update    (send_hs),
    .upd_first (idx_q == '0),
    .upd_id    (idx_q),
    .upd_count (snap_q[idx_q]),
    .max_count (trk_max),
    .max_id    (trk_id)
`ifdef VOTE_READER_TIE_DETECT_EN
    ,
    .tie       (trk_tie)
`endif
  );

endmodule

// File: tb/tb_vote_result_reader.sv
// Self-checking bench for vote_result_reader: directed scenarios plus a
// randomized loop, checked against a whole-snapshot reference model.
module tb_vote_result_reader;

  localparam int unsigned CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             mode;
  logic             start;
  logic [CNT_W-1:0] cand1_count;
  logic [CNT_W-1:0] cand2_count;
  logic [CNT_W-1:0] cand3_count;
  logic [CNT_W-1:0] cand4_count;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_kind;
  logic [1:0]       rd_id;
  logic [CNT_W-1:0] rd_data;
  logic             busy;
  logic [1:0]       winner_id;
  logic             winner_valid;
`ifdef VOTE_READER_TIE_DETECT_EN
  logic             tie;
`endif

  int checks = 0;
  int errors = 0;

  vote_result_reader #(
    .CNT_W (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .start        (start),
    .cand1_count  (cand1_count),
    .cand2_count  (cand2_count),
    .cand3_count  (cand3_count),
    .cand4_count  (cand4_count),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_kind      (rd_kind),
    .rd_id        (rd_id),
    .rd_data      (rd_data),
    .busy         (busy),
    .winner_id    (winner_id),
    .winner_valid (winner_valid)
`ifdef VOTE_READER_TIE_DETECT_EN
    ,
    .tie          (tie)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: winner is the lowest index holding the overall maximum;
  // a tie exists when more than one index holds it.
  task automatic model(input int c[4], output int wid, output int mx, output bit tie_exp);
    int n;
    mx = 0;
    foreach (c[i]) if (c[i] > mx) mx = c[i];
    wid = -1;
    n = 0;
    foreach (c[i]) begin
      if (c[i] == mx) begin
        n++;
        if (wid < 0) wid = i;
      end
    end
    tie_exp = (n > 1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expect one record; stall cycles first, then optional random ready.
  task automatic present(input string tag, input bit kind, input int id, input int data,
                         input int stall, input bit rnd);
    bit acc = 1'b0;
    for (int k = 0; k < 32 && !acc; k++) begin
      if (k < stall)          rd_ready = 1'b0;
      else if (rnd && k < 8)  rd_ready = 1'($urandom % 2);
      else                    rd_ready = 1'b1;
      if (rnd) begin
        start       = 1'($urandom % 2);
        cand1_count = CNT_W'($urandom);
        cand2_count = CNT_W'($urandom);
        cand3_count = CNT_W'($urandom);
        cand4_count = CNT_W'($urandom);
      end
      chk({tag, "_valid"}, rd_valid, 1);
      chk({tag, "_kind"}, rd_kind, kind);
      chk({tag, "_id"}, rd_id, id);
      chk({tag, "_data"}, rd_data, data);
      chk({tag, "_busy"}, busy, 1);
      acc = rd_ready;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic readout(input string tag, input int c0, input int c1, input int c2, input int c3,
                         input int stall_rec, input int stall_n, input bit rnd, input bit mutate);
    int  c[4];
    int  wid, mx;
    bit  tie_exp;
    c = '{c0, c1, c2, c3};
    cand1_count = CNT_W'(c0);
    cand2_count = CNT_W'(c1);
    cand3_count = CNT_W'(c2);
    cand4_count = CNT_W'(c3);
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_wv_clr"}, winner_valid, 0);
    if (mutate) cand3_count = 8'd200;
    for (int r = 0; r < 4; r++) begin
      present({tag, "_rec"}, 1'b0, r, c[r], (r == stall_rec) ? stall_n : 0, rnd);
    end
    model(c, wid, mx, tie_exp);
    present({tag, "_win"}, 1'b1, wid, mx, 0, rnd);
    chk({tag, "_idle_valid"}, rd_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_wv"}, winner_valid, 1);
    chk({tag, "_wid"}, winner_id, wid);
`ifdef VOTE_READER_TIE_DETECT_EN
    chk({tag, "_tie"}, tie, tie_exp);
`endif
  endtask

  initial begin
    int a0, a1;
    reset       = 1'b0;
    mode        = 1'b0;
    start       = 1'b0;
    rd_ready    = 1'b0;
    cand1_count = '0;
    cand2_count = '0;
    cand3_count = '0;
    cand4_count = '0;
    #3;
    chk("rst_valid", rd_valid, 0);
    chk("rst_kind", rd_kind, 0);
    chk("rst_id", rd_id, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wid", winner_id, 0);
    chk("rst_wv", winner_valid, 0);
`ifdef VOTE_READER_TIE_DETECT_EN
    chk("rst_tie", tie, 0);
`endif
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic readout.
    readout("basic", 5, 9, 3, 7, -1, 0, 1'b0, 1'b0);
    // Tie on max, lowest index wins; started back-to-back.
    readout("tie", 4, 8, 8, 2, -1, 0, 1'b0, 1'b0);
    // Consumer stalls record 2 for 3 cycles.
    readout("stall", 10, 20, 30, 40, 2, 3, 1'b0, 1'b0);
    // Live count changes after start are ignored.
    readout("snap", 5, 6, 3, 1, -1, 0, 1'b0, 1'b1);

    // Leaving result mode clears the latched winner; start is ignored.
    mode = 1'b0;
    tick();
    chk("m0_wv_clr", winner_valid, 0);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("m0_valid", rd_valid, 0);
      chk("m0_busy", busy, 0);
    end
    start = 1'b0;

    // Abort during record 1.
    cand1_count = 8'd11;
    cand2_count = 8'd22;
    cand3_count = 8'd33;
    cand4_count = 8'd44;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    present("abort_rec", 1'b0, 0, 11, 0, 1'b0);
    chk("abort_pre_id", rd_id, 1);
    rd_ready = 1'b0;
    mode     = 1'b0;
    tick();
    chk("abort_valid", rd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wv", winner_valid, 0);
    mode     = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_quiet", rd_valid, 0);
      chk("abort_wv_stay", winner_valid, 0);
    end

    // Reset asserted mid-SEND, off the clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    present("rstmid_rec", 1'b0, 0, 11, 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_valid", rd_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_id", rd_id, 0);
    chk("rstmid_data", rd_data, 0);
    chk("rstmid_wv", winner_valid, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstmid_quiet", rd_valid, 0);
    end
    readout("zero", 0, 0, 0, 0, -1, 0, 1'b0, 1'b0);

    // Randomized readouts: small values for frequent ties, random ready,
    // random start pulses while busy and random live-count churn.
    for (int n = 0; n < 25; n++) begin
      a0 = (n % 2 == 0) ? 7 : 255;
      a1 = $urandom_range(0, a0);
      readout("rnd", a1, $urandom_range(0, a0), $urandom_range(0, a0), $urandom_range(0, a0),
              $urandom_range(0, 4), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    rd_ready = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
